slc3_control_fsm: RTL and testbench

- Instruction-sequencing control unit for the SLC-3 CPU.
- Sits directly upstream of the datapath and drives every datapath load, gate, mux select and memory strobe.
- Runs fetch/decode/execute as a Moore FSM.
- Decode uses only IR opcode bits, IR[5] and the BEN flag fed back from the datapath.

---
 rtl/slc3_control_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_slc3_control_fsm.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_control_fsm.sv
// SLC-3 instruction-sequencing control unit: Moore fetch/decode/execute FSM
// driving every datapath load, bus gate, mux select and memory strobe.
module slc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S00, S22,
        S12, S04, S21, S06, S07,
        S25, S27, S23, S16, P1, P2
    } state_t;

    localparam int unsigned CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_WAIT);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          first;
    logic          access_done;
    logic          in_access;

    assign access_done = (cnt == LAST);
    assign in_access   = (state == S33) || (state == S25) || (state == S16);

    // Memory states are only ever entered from a different state, so the
    // counter restarts at zero simply by clearing it whenever we are not staying.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= HALTED;
            cnt   <= '0;
            first <= 1'b1;
        end else begin
            state <= state_next;
            first <= (state_next != state);
            if (in_access && (state_next == state))
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = '0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = '0;
        ALUK       = '0;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        case (state)
            HALTED: if (Run) state_next = S18;
            S18: begin
                GatePC     = 1'b1;
                LD_MAR     = 1'b1;
                LD_PC      = 1'b1;
                state_next = S33;
            end
            S33, S25: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = access_done;
                if (access_done) state_next = (state == S33) ? S35 : S27;
            end
            S35: begin
                GateMDR    = 1'b1;
                LD_IR      = 1'b1;
                state_next = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: state_next = S01;
                    4'b0101: state_next = S05;
                    4'b1001: state_next = S09;
                    4'b0000: state_next = S00;
                    4'b1100: state_next = S12;
                    4'b0100: state_next = S04;
                    4'b0110: state_next = S06;
                    4'b0111: state_next = S07;
                    4'b1101: state_next = P1;
                    default: state_next = S18;
                endcase
            end
            S01, S05, S09: begin
                SR1MUX     = 1'b1;
                SR2MUX     = IR_5;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_next = S18;
                if (state == S05) ALUK = 2'b01;
                else if (state == S09) ALUK = 2'b10;
            end
            S00: state_next = BEN ? S22 : S18;
            S22: begin
                ADDR2MUX   = 2'b10;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                state_next = S18;
            end
            S12: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                state_next = S18;
            end
            S04: begin
                GatePC     = 1'b1;
                DRMUX      = 1'b1;
                LD_REG     = 1'b1;
                state_next = S21;
            end
            S21: begin
                ADDR2MUX   = 2'b11;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                state_next = S18;
            end
            S06, S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_next = (state == S06) ? S25 : S23;
            end
            S27: begin
                GateMDR    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                state_next = S18;
            end
            S23: begin
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                LD_MDR     = 1'b1;
                state_next = S16;
            end
            S16: begin
                Mem_WE = 1'b0;
                if (access_done) state_next = S18;
            end
            P1: begin
                LD_LED = first;
                if (Continue) state_next = P2;
            end
            P2: if (!Continue) state_next = S18;
            default: state_next = HALTED;
        endcase
    end

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Randomized + directed bench for slc3_control_fsm against a per-instruction
// micro-op list model; every cycle the DUT control word is compared.
module tb_slc3_control_fsm;

    localparam int MW = 2;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

    slc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic       mio_en, mem_oe, mem_we;
    } ctl_t;

    ctl_t act;
    assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                  SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_OE, Mem_WE};

    typedef enum {M_HALT, M_RUN, M_P1, M_P2} mmode_t;

    mmode_t     mode;
    ctl_t       q[$];
    ctl_t       trace[$];
    ctl_t       last_act;
    bit         pause_pending, led_first, rand_mode;
    logic [3:0] cur_op;
    logic       cur_ir5, cur_ben;
    int         checks = 0;
    int         failures = 0;

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    task automatic check(input string nm, input bit ok, input logic [31:0] a, input logic [31:0] r);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, a, r, $time);
        end
    endtask

    // One instruction as the ordered list of control words it must produce.
    task automatic build(input logic [3:0] op, input logic i5, input logic b);
        ctl_t c;
        c = idle(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; q.push_back(c);
        for (int i = 0; i <= MW; i++) begin
            c = idle(); c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = (i == MW); q.push_back(c);
        end
        c = idle(); c.gate_mdr = 1; c.ld_ir = 1; q.push_back(c);
        c = idle(); c.ld_ben = 1; q.push_back(c);
        case (op)
            4'd1, 4'd5, 4'd9: begin
                c = idle(); c.sr1mux = 1; c.sr2mux = i5; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
                c.aluk = (op == 4'd1) ? 2'd0 : (op == 4'd5) ? 2'd1 : 2'd2;
                q.push_back(c);
            end
            4'd0: begin
                q.push_back(idle());
                if (b) begin
                    c = idle(); c.addr2mux = 2'd2; c.pcmux = 2'd2; c.ld_pc = 1; q.push_back(c);
                end
            end
            4'd12: begin
                c = idle(); c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'd2; c.ld_pc = 1; q.push_back(c);
            end
            4'd4: begin
                c = idle(); c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; q.push_back(c);
                c = idle(); c.addr2mux = 2'd3; c.pcmux = 2'd2; c.ld_pc = 1; q.push_back(c);
            end
            4'd6, 4'd7: begin
                c = idle(); c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'd1; c.gate_marmux = 1; c.ld_mar = 1;
                q.push_back(c);
                for (int i = 0; i <= MW; i++) begin
                    c = idle();
                    if (op == 4'd6) begin c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = (i == MW); end
                    else c.mem_we = 0;
                    if (op == 4'd6 || i == 0) begin end
                    if (op == 4'd7 && i == 0) begin
                        ctl_t s = idle();
                        s.aluk = 2'd3; s.gate_alu = 1; s.ld_mdr = 1;
                        q.push_back(s);
                    end
                    q.push_back(c);
                end
                if (op == 4'd6) begin
                    c = idle(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; q.push_back(c);
                end
            end
            4'd13: pause_pending = 1;
            default: ;
        endcase
    endtask

    task automatic cycle(input bit do_reset);
        ctl_t e;
        if (mode == M_RUN && q.size() == 0) begin
            if (rand_mode) begin
                cur_op  = 4'($urandom_range(0, 15));
                cur_ir5 = 1'($urandom_range(0, 1));
                cur_ben = 1'($urandom_range(0, 1));
            end
            build(cur_op, cur_ir5, cur_ben);
        end
        Opcode = cur_op; IR_5 = cur_ir5; BEN = cur_ben;
        e = (mode == M_RUN) ? q[0] : idle();
        if (mode == M_P1) e.ld_led = led_first;
        @(negedge Clk);
        check("ctl_word", act === e, 32'(act), 32'(e));
        last_act = act;
        trace.push_back(act);
        if (do_reset) begin
            #1 Reset = 1;
            #1 check("async_reset", act === idle(), 32'(act), 32'(idle()));
            q.delete(); mode = M_HALT; pause_pending = 0;
            #1 Reset = 0;
        end
        @(posedge Clk);
        case (mode)
            M_HALT: if (Run) mode = M_RUN;
            M_RUN: begin
                void'(q.pop_front());
                if (q.size() == 0 && pause_pending) begin
                    mode = M_P1; led_first = 1; pause_pending = 0;
                end
            end
            M_P1: begin led_first = 0; if (Continue) mode = M_P2; end
            M_P2: if (!Continue) mode = M_RUN;
            default: ;
        endcase
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic i5, input logic b, output int len);
        cur_op = op; cur_ir5 = i5; cur_ben = b;
        trace.delete();
        len = 0;
        do begin
            cycle(1'b0);
            len++;
        end while (mode == M_RUN && q.size() != 0 && len < 64);
    endtask

    function automatic int count(input int sel);
        int n = 0;
        foreach (trace[i]) begin
            case (sel)
                0: n += int'(trace[i].ld_mdr);
                1: n += int'(trace[i].ld_pc);
                2: n += int'(trace[i].ld_reg);
                3: n += int'(!trace[i].mem_we);
                4: n += int'(!trace[i].mem_oe);
                5: n += int'(trace[i].ld_led);
                default: n += int'(trace[i].gate_pc);
            endcase
        end
        return n;
    endfunction

    initial begin
        int len;
        Reset = 1; Run = 0; Continue = 0; Opcode = '0; IR_5 = 0; BEN = 0;
        cur_op = '0; cur_ir5 = 0; cur_ben = 0;
        mode = M_HALT; pause_pending = 0; led_first = 0; rand_mode = 0;
        @(negedge Clk);
        check("reset_oe_we", Mem_OE && Mem_WE, {30'd0, Mem_OE, Mem_WE}, 32'd3);
        check("reset_idle", act === idle(), 32'(act), 32'(idle()));
        Reset = 0;
        @(posedge Clk); #1;

        Run = 1; cycle(1'b0); Run = 0;

        run_instr(4'd1, 1'b1, 1'b0, len);
        check("add_len", len == 7, len, 7);
        check("add_mdr_cycle", trace[3].ld_mdr && count(0) == 1, count(0), 1);
        check("add_s01", trace[6].ld_reg && trace[6].ld_cc && trace[6].sr2mux && trace[6].aluk == 2'b00,
              32'(trace[6]), 32'(trace[6]));

        run_instr(4'd0, 1'b0, 1'b0, len);
        check("br_nt_len", len == 7, len, 7);
        check("br_nt_ldpc", count(1) == 1, count(1), 1);

        run_instr(4'd0, 1'b0, 1'b1, len);
        check("br_t_len", len == 8, len, 8);
        check("br_t_s22", trace[7].pcmux == 2'b10 && trace[7].addr2mux == 2'b10 && trace[7].ld_pc,
              {trace[7].pcmux, trace[7].addr2mux}, 32'ha);

        run_instr(4'd7, 1'b0, 1'b0, len);
        check("str_len", len == 11, len, 11);
        check("str_we_cycles", count(3) == 3, count(3), 3);
        check("str_oe_cycles", count(4) == 3, count(4), 3);
        check("str_s23", trace[7].gate_alu && trace[7].ld_mdr && !trace[7].mio_en, 32'(trace[7]), 32'(trace[7]));

        run_instr(4'd6, 1'b0, 1'b0, len);
        check("ldr_len", len == 11, len, 11);
        check("ldr_mdr_loads", count(0) == 2, count(0), 2);

        run_instr(4'd4, 1'b0, 1'b0, len);
        check("jsr_len", len == 8, len, 8);

        run_instr(4'd15, 1'b1, 1'b1, len);
        check("nop_len", len == 6, len, 6);
        check("nop_no_side", count(2) == 0 && count(3) == 0 && count(1) == 1, count(2) + count(3), 0);

        run_instr(4'd13, 1'b0, 1'b0, len);
        check("pause_len", len == 6, len, 6);
        trace.delete();
        Continue = 0;
        repeat (10) cycle(1'b0);
        check("pause_led_pulse", count(5) == 1 && trace[0].ld_led, count(5), 1);
        Continue = 1;
        repeat (5) cycle(1'b0);
        check("pause_hold", count(6) == 0, count(6), 0);
        Continue = 0;
        cur_op = 4'd1; cur_ir5 = 0; cur_ben = 0;
        cycle(1'b0);
        cycle(1'b0);
        check("resume_s18", last_act.gate_pc && last_act.ld_mar, 32'(last_act), 32'(last_act));

        cycle(1'b0);
        cycle(1'b1);
        check("rst_mid_read_oe_before", !last_act.mem_oe, last_act.mem_oe, 0);
        check("rst_mid_read_after", Mem_OE && !LD_MDR, {30'd0, Mem_OE, LD_MDR}, 32'd2);
        Run = 1; cycle(1'b0); Run = 0;
        cycle(1'b0);
        check("restart_s18", last_act.gate_pc && last_act.ld_mar, 32'(last_act), 32'(last_act));

        rand_mode = 1;
        for (int n = 0; n < 4000; n++) begin
            Run      = ($urandom_range(0, 3) == 0);
            Continue = ($urandom_range(0, 2) == 0);
            cycle($urandom_range(0, 249) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
